// File: rtl/sprite_shadow_bank.sv
// Avalon-MM shadow/active descriptor bank for the sprite controller.
// Software writes land in the shadow bank; frame_start copies shadow to active so the display never tears.
module sprite_shadow_bank #(
   parameter int N_SPRITES = 30,
   parameter int FCNT_W    = 16
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      chipselect,
   input  logic                      write,
   input  logic                      read,
   input  logic [5:0]                address,
   input  logic [31:0]               writedata,
   output logic [31:0]               readdata,
   input  logic                      frame_start,
   output logic [N_SPRITES*32-1:0]   active_sprites,
   output logic                      commit_pulse
);

   localparam logic [6:0] SPRITE_LIM = 7'(N_SPRITES);
   localparam logic [5:0] ADDR_CLEAR = 6'd60;
   localparam logic [5:0] ADDR_STAT  = 6'd61;
   localparam logic [5:0] ADDR_AUTO  = 6'd62;
   localparam logic [5:0] ADDR_FORCE = 6'd63;

   logic                    wr_en;
   logic                    rd_en;
   logic                    sprite_hit;
   logic                    commit;
   logic [N_SPRITES*32-1:0] shadow_flat;

   logic                    pending_q, pending_d;
   logic                    vblank_q, vblank_d;
   logic                    auto_q, auto_d;
   logic [FCNT_W-1:0]       fcnt_q, fcnt_d;
   logic [31:0]             readdata_q, readdata_d;
   logic                    commit_pulse_q;
   logic [31:0]             rd_word;

   // A simultaneous read is dropped when write is also asserted.
   assign wr_en      = chipselect & write;
   assign rd_en      = chipselect & read & ~write;
   assign sprite_hit = ({1'b0, address} < SPRITE_LIM);
   assign commit     = frame_start & auto_q & pending_q;

   generate
      for (genvar gi = 0; gi < N_SPRITES; gi++) begin : g_sprite
         logic [31:0] shadow_q, shadow_d;
         logic [31:0] active_q, active_d;

         always_comb begin
            shadow_d = shadow_q;
            if (wr_en && address == ADDR_CLEAR) begin
               shadow_d = '0;
            end else if (wr_en && address == 6'(gi)) begin
               shadow_d = writedata;
            end
            // Commit samples the pre-edge shadow, so same-cycle writes go to the next frame.
            active_d = commit ? shadow_q : active_q;
         end

         always_ff @(posedge clk) begin
            if (!reset_n) begin
               shadow_q <= '0;
               active_q <= '0;
            end else begin
               shadow_q <= shadow_d;
               active_q <= active_d;
            end
         end

         assign shadow_flat[gi*32 +: 32]    = shadow_q;
         assign active_sprites[gi*32 +: 32] = active_q;
      end
   endgenerate

   always_comb begin
      rd_word = 32'd0;
      case (address)
         ADDR_STAT:  rd_word = {15'b0, pending_q, 8'b0, 7'b0, vblank_q};
         ADDR_AUTO:  rd_word = {31'b0, auto_q};
         ADDR_FORCE: rd_word = 32'(fcnt_q);
         default: begin
            for (int i = 0; i < N_SPRITES; i++) begin
               if (address == 6'(i)) rd_word = shadow_flat[i*32 +: 32];
            end
         end
      endcase
   end

   always_comb begin
      pending_d = pending_q;
      if (wr_en && (sprite_hit || address == ADDR_CLEAR || address == ADDR_FORCE)) begin
         pending_d = 1'b1;
      end else if (commit) begin
         pending_d = 1'b0;
      end

      auto_d = auto_q;
      if (wr_en && address == ADDR_AUTO) auto_d = writedata[0];

      // Flag set by frame_start beats the clear-on-read.
      vblank_d = vblank_q;
      if (frame_start) begin
         vblank_d = 1'b1;
      end else if (rd_en && address == ADDR_STAT) begin
         vblank_d = 1'b0;
      end

      fcnt_d     = frame_start ? fcnt_q + FCNT_W'(1) : fcnt_q;
      readdata_d = rd_en ? rd_word : readdata_q;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pending_q      <= 1'b0;
         vblank_q       <= 1'b0;
         auto_q         <= 1'b1;
         fcnt_q         <= '0;
         readdata_q     <= 32'd0;
         commit_pulse_q <= 1'b0;
      end else begin
         pending_q      <= pending_d;
         vblank_q       <= vblank_d;
         auto_q         <= auto_d;
         fcnt_q         <= fcnt_d;
         readdata_q     <= readdata_d;
         commit_pulse_q <= commit;
      end
   end

   assign readdata     = readdata_q;
   assign commit_pulse = commit_pulse_q;

endmodule
